// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin burst-read arbiter in front of a single-port,
// 1-cycle-latency ROM. Each grant issues len+1 consecutive addresses and
// returns the data tagged with the owner, plus a done pulse on the last word.
module rom_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0,
   input  logic                  req1,
   input  logic [ADDR_WIDTH-1:0] base0,
   input  logic [ADDR_WIDTH-1:0] base1,
   input  logic [LEN_WIDTH-1:0]  len0,
   input  logic [LEN_WIDTH-1:0]  len1,
   output logic                  gnt0,
   output logic                  gnt1,
   output logic                  done0,
   output logic                  done1,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_vld,
   output logic                  dout_id,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_n;
   logic [LEN_WIDTH-1:0]    cnt, cnt_n;
   logic                    owner, owner_n;
   logic                    last_id, last_n;
   logic [ADDR_WIDTH-1:0]   rom_addr_r, rom_addr_n;
   logic [1:0]              gnt_r, gnt_n;
   logic [1:0]              done_r, done_n;
   logic                    vld_r, vld_n;
   logic                    win;
   logic [ADDR_WIDTH-1:0]   sel_base;
   logic [LEN_WIDTH-1:0]    sel_len;

   // Next-state and next-register logic for arbitration and burst issue.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case can infer a latch.
      state_n    = state;
      addr_n     = addr_reg;
      cnt_n      = cnt;
      owner_n    = owner;
      last_n     = last_id;
      rom_addr_n = rom_addr_r;
      gnt_n      = 2'b00;
      done_n     = 2'b00;
      vld_n      = 1'b0;
      // On a tie the requester not served last wins; otherwise the lone requester wins.
      win        = (req0 && req1) ? ~last_id : req1;
      sel_base   = win ? base1 : base0;
      sel_len    = win ? len1 : len0;

      case (state)
         IDLE: begin
            if (req0 || req1) begin
               owner_n    = win;
               rom_addr_n = sel_base;
               addr_n     = sel_base + ADDR_ONE;
               cnt_n      = sel_len;
               gnt_n      = win ? 2'b10 : 2'b01;
               state_n    = ISSUE;
            end
         end
         ISSUE: begin
            // The word addressed in this cycle comes back from the ROM next cycle.
            vld_n = 1'b1;
            if (cnt == '0) begin
               done_n  = owner ? 2'b10 : 2'b01;
               state_n = DRAIN;
            end else begin
               rom_addr_n = addr_reg;
               addr_n     = addr_reg + ADDR_ONE;
               cnt_n      = cnt - LEN_ONE;
            end
         end
         DRAIN: begin
            last_n  = owner;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // State and datapath registers; synchronous reset aborts any burst silently.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state      <= IDLE;
         addr_reg   <= '0;
         cnt        <= '0;
         owner      <= 1'b0;
         last_id    <= 1'b1;
         rom_addr_r <= '0;
         gnt_r      <= 2'b00;
         done_r     <= 2'b00;
         vld_r      <= 1'b0;
      end else begin
         state      <= state_n;
         addr_reg   <= addr_n;
         cnt        <= cnt_n;
         owner      <= owner_n;
         last_id    <= last_n;
         rom_addr_r <= rom_addr_n;
         gnt_r      <= gnt_n;
         done_r     <= done_n;
         vld_r      <= vld_n;
      end
   end

   assign gnt0     = gnt_r[0];
   assign gnt1     = gnt_r[1];
   assign done0    = done_r[0];
   assign done1    = done_r[1];
   assign rom_addr = rom_addr_r;
   assign dout_vld = vld_r;
   assign dout     = vld_r ? rom_q : '0;
   assign dout_id  = owner;
   assign busy     = (state != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and randomized stimulus against a burst-timeline
// reference model (each grant predicts its full cycle-by-cycle outputs).
module tb_rom_arbiter;
   localparam int DW = 8;
   localparam int AW = 10;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0 = 1'b0, req1 = 1'b0;
   logic [AW-1:0] base0 = '0, base1 = '0;
   logic [LW-1:0] len0 = '0, len1 = '0;
   logic          gnt0, gnt1, done0, done1, dout_vld, dout_id, busy;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_q, dout;

   rom_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .base0(base0), .base1(base1),
      .len0(len0), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1),
      .done0(done0), .done1(done1),
      .rom_addr(rom_addr), .rom_q(rom_q),
      .dout(dout), .dout_vld(dout_vld), .dout_id(dout_id), .busy(busy)
   );

   always #10 clk = ~clk;

   // ROM model: 1-cycle registered read.
   logic [DW-1:0] rom_mem [0:(1<<AW)-1];
   always @(posedge clk) rom_q <= rom_mem[rom_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Staged stimulus, applied at the next falling edge.
   logic          s_rst = 1'b1, s_req0 = 1'b0, s_req1 = 1'b0;
   logic [AW-1:0] s_base0 = '0, s_base1 = '0;
   logic [LW-1:0] s_len0 = '0, s_len1 = '0;
   bit            hold0 = 1'b0, hold1 = 1'b0;

   // Reference model: one burst descriptor plus arbitration memory.
   bit            m_en = 1'b0, m_active = 1'b0, m_last = 1'b1, m_owner = 1'b0;
   logic [AW-1:0] m_base = '0;
   int            m_len = 0, m_start = 0, m_free = 0, m_zero = -1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_cycle();
      bit            in_b, e_vld;
      int            k;
      logic [AW-1:0] ea;
      if (!m_en) return;
      if (cyc == m_zero) begin
         check("rst_gnt0", gnt0, 0);   check("rst_gnt1", gnt1, 0);
         check("rst_done0", done0, 0); check("rst_done1", done1, 0);
         check("rst_vld", dout_vld, 0); check("rst_id", dout_id, 0);
         check("rst_dout", dout, 0);   check("rst_addr", rom_addr, 0);
         check("rst_busy", busy, 0);
      end else begin
         in_b  = m_active && cyc >= m_start && cyc <= m_start + m_len + 1;
         k     = cyc - m_start;
         e_vld = in_b && k >= 1;
         check("gnt0", gnt0, in_b && k == 0 && !m_owner);
         check("gnt1", gnt1, in_b && k == 0 && m_owner);
         check("done0", done0, in_b && k == m_len + 1 && !m_owner);
         check("done1", done1, in_b && k == m_len + 1 && m_owner);
         check("dout_vld", dout_vld, e_vld);
         check("busy", busy, in_b);
         if (in_b) begin
            ea = m_base + AW'((k <= m_len) ? k : m_len);
            check("rom_addr", rom_addr, ea);
         end
         if (e_vld) begin
            ea = m_base + AW'(k - 1);
            check("dout", dout, rom_mem[ea]);
            check("dout_id", dout_id, m_owner);
         end else begin
            check("dout_idle", dout, 0);
         end
         if (in_b && k == m_len + 1) begin
            m_last   = m_owner;
            m_active = 1'b0;
         end
      end
   endtask

   // One clock: check this cycle's outputs, drive staged inputs, advance model.
   task automatic cycle();
      @(negedge clk);
      check_cycle();
      rst = s_rst; req0 = s_req0; req1 = s_req1;
      base0 = s_base0; base1 = s_base1; len0 = s_len0; len1 = s_len1;
      if (rst) begin
         m_en = 1'b1; m_active = 1'b0; m_last = 1'b1;
         m_zero = cyc + 1; m_free = cyc + 1;
      end else if (m_en && cyc >= m_free && (req0 || req1)) begin
         m_owner  = (req0 && req1) ? !m_last : req1;
         m_base   = m_owner ? base1 : base0;
         m_len    = int'(m_owner ? len1 : len0);
         m_start  = cyc + 1;
         m_free   = cyc + m_len + 3;
         m_active = 1'b1;
         if (!m_owner && !hold0) s_req0 = 1'b0;
         if (m_owner && !hold1) s_req1 = 1'b0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset(input int n);
      s_rst = 1'b1;
      run(n);
      s_rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'(i);

      // Reset then a single 4-word burst from requester 0.
      do_reset(2);
      s_base0 = 10'h010; s_len0 = 10'd3; s_req0 = 1'b1;
      run(10);

      // Both requesters held: alternating grants starting with 0.
      do_reset(1);
      s_base0 = 10'h100; s_len0 = 10'd2; s_base1 = 10'h200; s_len1 = 10'd1;
      hold0 = 1'b1; hold1 = 1'b1; s_req0 = 1'b1; s_req1 = 1'b1;
      run(24);
      hold0 = 1'b0; hold1 = 1'b0; s_req0 = 1'b0; s_req1 = 1'b0;
      run(8);

      // Address wrap-around for requester 1.
      s_base1 = 10'h3FE; s_len1 = 10'd3; s_req1 = 1'b1;
      run(9);

      // Single-word burst.
      s_base0 = 10'h055; s_len0 = 10'd0; s_req0 = 1'b1;
      run(5);

      // Mid-burst reset on the 3rd data cycle, then requester 1 alone.
      s_base0 = 10'h020; s_len0 = 10'd7; s_req0 = 1'b1;
      run(4);
      s_rst = 1'b1;
      run(1);
      s_rst = 1'b0; s_req1 = 1'b1; s_base1 = 10'h0C0; s_len1 = 10'd2;
      run(8);

      // Randomized traffic: base/len change every cycle, occasional reset.
      for (int i = 0; i < (1 << AW); i++) rom_mem[i] = DW'($urandom);
      for (int i = 0; i < 1500; i++) begin
         if (!s_req0 && $urandom_range(0, 3) == 0) s_req0 = 1'b1;
         if (!s_req1 && $urandom_range(0, 3) == 0) s_req1 = 1'b1;
         s_base0 = AW'($urandom); s_base1 = AW'($urandom);
         s_len0  = LW'($urandom_range(0, 6)); s_len1 = LW'($urandom_range(0, 6));
         s_rst   = ($urandom_range(0, 149) == 0);
         cycle();
      end
      s_rst = 1'b0; s_req0 = 1'b0; s_req1 = 1'b0;
      run(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
